// File: rtl/mult_booth_seq_if.sv
// Start/operand/result bundle between the execute stage and the sequential Booth multiplier.
// master drives start and operands; slave returns the product, overflow flag and status.
interface mult_booth_seq_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier: 32 steps per operation, low 32 product bits out.
// Define MULT_OVF_EXCEPTION_EN to compute the signed-overflow exception; otherwise it is tied 0.
module mult_booth_seq (
  input  logic             clock,
  input  logic             reset,
  mult_booth_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [32:0] m_q, m_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic        start;
  logic        last_step;
  logic [32:0] sum;
  logic [32:0] step_acc;
  logic [31:0] step_q;
  logic        ovf;

  assign start     = bus.ctrl_MULT;
  assign last_step = (state_q == StRun) && (cnt_q == 6'd31);

  // Booth recoding of {Q[0], Qm1}, then arithmetic shift of {ACC, Q, Qm1}.
  always_comb begin
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  assign step_acc = {sum[32], sum[32:1]};
  assign step_q   = {sum[0], q_q[31:1]};

`ifdef MULT_OVF_EXCEPTION_EN
  logic [63:0] product;
  logic [32:0] upper;
  assign product = {step_acc[31:0], step_q};
  assign upper   = product[63:31];
  assign ovf     = !((upper == '0) || (upper == '1));
`else
  assign ovf = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start pulse restarts from any state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:   if (cnt_q == 6'd31) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    m_d      = m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = 1'b0;
    if (start) begin
      m_d    = {bus.data_operandA[31], bus.data_operandA};
      acc_d  = '0;
      q_d    = bus.data_operandB;
      qm1_d  = 1'b0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (state_q == StRun) begin
      acc_d  = step_acc;
      q_d    = step_q;
      qm1_d  = q_q[0];
      cnt_d  = cnt_q + 6'd1;
      busy_d = !last_step;
      if (last_step) begin
        result_d = step_q;
        exc_d    = ovf;
        rdy_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      m_q      <= m_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
